// File: rtl/serial_sum_pkg.sv
// Shared types and sizing helpers for the serial sum collector and its shift register.
package serial_sum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      HOLD
   } state_t;

   // Bit counter width: clog2 of the word width, never narrower than one bit.
   function automatic int count_width(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int result_width(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/serial_sum_collector_shift_reg.sv
// LSB-first right-shift register with clear and parallel load, shared with the operand stage.
module sum_shift_reg #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] next_word
);

   logic [WIDTH-1:0] shreg;

   // New bits enter at the top so that after WIDTH shifts bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_single
         assign next_word = din;
      end else begin : g_multi
         assign next_word = {din, shreg[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
      end else if (clear) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= load_value;
      end else if (shift_en) begin
         shreg <= next_word;
      end
   end

endmodule

// File: rtl/serial_sum_collector.sv
// Deserializes the bit-serial adder output into a WIDTH+1-bit result with valid/ready handoff.
// Optional res_parity output enabled by defining SUM_COLLECT_PARITY_EN.
module serial_sum_collector
   import serial_sum_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           bit_valid,
   output logic           bit_ready,
   input  logic           sum_bit,
   input  logic           carry_bit,
   input  logic           first,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [WIDTH:0] result,
   output logic           frag
`ifdef SUM_COLLECT_PARITY_EN
   ,
   output logic           res_parity
`endif
);

   localparam int CNT_W = count_width(WIDTH);
   localparam int RES_W = result_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t           state, next_state;
   logic [CNT_W-1:0] count, count_next, bit_index;
   logic [WIDTH-1:0] next_word;
   logic [RES_W-1:0] result_next;
   logic             accept, last_bit;
   logic             shift_en, load_result, frag_set, shreg_clear;

   assign bit_ready   = (state != HOLD);
   assign accept      = bit_valid && bit_ready;
   // A first-flagged bit always restarts at position 0, even mid-word.
   assign bit_index   = first ? '0 : count;
   assign last_bit    = (bit_index == LAST_IDX);
   assign result_next = {carry_bit, next_word};

   sum_shift_reg #(
      .WIDTH(WIDTH)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .clear     (shreg_clear),
      .load      (1'b0),
      .load_value('0),
      .shift_en  (shift_en),
      .din       (sum_bit),
      .next_word (next_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      count_next  = count;
      shift_en    = 1'b0;
      load_result = 1'b0;
      frag_set    = 1'b0;
      shreg_clear = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (first) begin
                  shift_en = 1'b1;
                  if (last_bit) begin
                     load_result = 1'b1;
                     count_next  = '0;
                     next_state  = HOLD;
                  end else begin
                     count_next  = bit_index + CNT_W'(1);
                     next_state  = COLLECT;
                  end
               end else begin
                  frag_set = 1'b1;
               end
            end
         end
         COLLECT: begin
            if (accept) begin
               shift_en = 1'b1;
               frag_set = first;
               if (last_bit) begin
                  load_result = 1'b1;
                  count_next  = '0;
                  next_state  = HOLD;
               end else begin
                  count_next  = bit_index + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (res_ready) begin
               shreg_clear = 1'b1;
               next_state  = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Result stays untouched after handoff; only res_valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         result     <= '0;
         res_valid  <= 1'b0;
         frag       <= 1'b0;
`ifdef SUM_COLLECT_PARITY_EN
         res_parity <= 1'b0;
`endif
      end else begin
         count <= count_next;
         frag  <= frag_set;
         if (load_result) begin
            result     <= result_next;
            res_valid  <= 1'b1;
`ifdef SUM_COLLECT_PARITY_EN
            res_parity <= ^result_next;
`endif
         end else if (state == HOLD && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed self-checking bench for serial_sum_collector with WIDTH=3.
module tb_serial_sum_collector;

   logic       clk;
   logic       rst;
   logic       bit_valid;
   logic       bit_ready;
   logic       sum_bit;
   logic       carry_bit;
   logic       first;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] result;
   logic       frag;
`ifdef SUM_COLLECT_PARITY_EN
   logic       res_parity;
`endif

   int checks = 0;
   int errors = 0;

   serial_sum_collector #(
      .WIDTH(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .sum_bit   (sum_bit),
      .carry_bit (carry_bit),
      .first     (first),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .result    (result),
      .frag      (frag)
`ifdef SUM_COLLECT_PARITY_EN
      ,
      .res_parity(res_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Presents one bit for a single clock; returns 1 time unit after the edge.
   task automatic drive_bit(input logic s, input logic c, input logic f);
      bit_valid = 1'b1;
      sum_bit   = s;
      carry_bit = c;
      first     = f;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      first     = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
      checks++; if (result !== 4'b0000) begin errors++; $display("[TB] FAIL reset_result: got %b expected 0000", result); end
      checks++; if (frag !== 1'b0) begin errors++; $display("[TB] FAIL reset_frag: got %b expected 0", frag); end
      checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_bit_ready: got %b expected 1", bit_ready); end
`ifdef SUM_COLLECT_PARITY_EN
      checks++; if (res_parity !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity: got %b expected 0", res_parity); end
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycle();
   endtask

   task automatic test_add_5_3();
      drive_bit(1'b0, 1'b1, 1'b1);
      drive_bit(1'b0, 1'b1, 1'b0);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL add53_early_valid: got %b expected 0", res_valid); end
      drive_bit(1'b0, 1'b1, 1'b0);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL add53_valid: got %b expected 1", res_valid); end
      checks++; if (result !== 4'b1000) begin errors++; $display("[TB] FAIL add53_result: got %b expected 1000", result); end
      checks++; if (bit_ready !== 1'b0) begin errors++; $display("[TB] FAIL add53_bit_ready: got %b expected 0", bit_ready); end
`ifdef SUM_COLLECT_PARITY_EN
      checks++; if (res_parity !== 1'b1) begin errors++; $display("[TB] FAIL add53_parity: got %b expected 1", res_parity); end
`endif
      release_result();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL add53_release_valid: got %b expected 0", res_valid); end
      checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL add53_release_ready: got %b expected 1", bit_ready); end
      checks++; if (result !== 4'b1000) begin errors++; $display("[TB] FAIL add53_result_kept: got %b expected 1000", result); end
   endtask

   task automatic test_hold_2_1();
      drive_bit(1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b0);
      drive_bit(1'b0, 1'b0, 1'b0);
      // Offer new bits during HOLD; they must be refused and cause no fragment.
      bit_valid = 1'b1;
      first     = 1'b1;
      sum_bit   = 1'b1;
      carry_bit = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (result !== 4'b0011) begin errors++; $display("[TB] FAIL hold_result[%0d]: got %b expected 0011", i, result); end
         checks++; if (bit_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_bit_ready[%0d]: got %b expected 0", i, bit_ready); end
         checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", i, res_valid); end
         checks++; if (frag !== 1'b0) begin errors++; $display("[TB] FAIL hold_frag[%0d]: got %b expected 0", i, frag); end
         idle_cycle();
      end
`ifdef SUM_COLLECT_PARITY_EN
      checks++; if (res_parity !== 1'b0) begin errors++; $display("[TB] FAIL hold_parity: got %b expected 0", res_parity); end
`endif
      bit_valid = 1'b0;
      first     = 1'b0;
      release_result();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid: got %b expected 0", res_valid); end
      checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_ready: got %b expected 1", bit_ready); end
   endtask

   task automatic test_stray_bit();
      drive_bit(1'b1, 1'b0, 1'b0);
      checks++; if (frag !== 1'b1) begin errors++; $display("[TB] FAIL stray_frag: got %b expected 1", frag); end
      checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL stray_bit_ready: got %b expected 1", bit_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL stray_valid: got %b expected 0", res_valid); end
      idle_cycle();
      checks++; if (frag !== 1'b0) begin errors++; $display("[TB] FAIL stray_frag_pulse: got %b expected 0", frag); end
      drive_bit(1'b0, 1'b1, 1'b1);
      drive_bit(1'b1, 1'b1, 1'b0);
      drive_bit(1'b1, 1'b1, 1'b0);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL add77_valid: got %b expected 1", res_valid); end
      checks++; if (result !== 4'b1110) begin errors++; $display("[TB] FAIL add77_result: got %b expected 1110", result); end
`ifdef SUM_COLLECT_PARITY_EN
      checks++; if (res_parity !== 1'b1) begin errors++; $display("[TB] FAIL add77_parity: got %b expected 1", res_parity); end
`endif
      release_result();
   endtask

   task automatic test_restart();
      drive_bit(1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b0);
      checks++; if (frag !== 1'b0) begin errors++; $display("[TB] FAIL restart_no_frag: got %b expected 0", frag); end
      drive_bit(1'b0, 1'b1, 1'b1);
      checks++; if (frag !== 1'b1) begin errors++; $display("[TB] FAIL restart_frag: got %b expected 1", frag); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_valid: got %b expected 0", res_valid); end
      idle_cycle();
      checks++; if (frag !== 1'b0) begin errors++; $display("[TB] FAIL restart_frag_pulse: got %b expected 0", frag); end
      drive_bit(1'b1, 1'b0, 1'b0);
      idle_cycle();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL restart_gap_valid: got %b expected 0", res_valid); end
      drive_bit(1'b0, 1'b0, 1'b0);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL restart_done_valid: got %b expected 1", res_valid); end
      checks++; if (result !== 4'b0010) begin errors++; $display("[TB] FAIL restart_result: got %b expected 0010", result); end
      release_result();
   endtask

   task automatic test_async_reset();
      drive_bit(1'b1, 1'b0, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (result !== 4'b0000) begin errors++; $display("[TB] FAIL arst_collect_result: got %b expected 0000", result); end
      checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_collect_ready: got %b expected 1", bit_ready); end
      rst = 1'b0;
      idle_cycle();
      drive_bit(1'b0, 1'b1, 1'b1);
      drive_bit(1'b0, 1'b1, 1'b0);
      drive_bit(1'b0, 1'b1, 1'b0);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_hold_valid: got %b expected 1", res_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_hold_valid: got %b expected 0", res_valid); end
      checks++; if (result !== 4'b0000) begin errors++; $display("[TB] FAIL arst_hold_result: got %b expected 0000", result); end
      checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_hold_ready: got %b expected 1", bit_ready); end
      rst = 1'b0;
      idle_cycle();
      drive_bit(1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1'b0, 1'b0);
      drive_bit(1'b0, 1'b0, 1'b0);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_clean_valid: got %b expected 1", res_valid); end
      checks++; if (result !== 4'b0011) begin errors++; $display("[TB] FAIL arst_clean_result: got %b expected 0011", result); end
      release_result();
   endtask

   initial begin
      bit_valid = 1'b0;
      sum_bit   = 1'b0;
      carry_bit = 1'b0;
      first     = 1'b0;
      res_ready = 1'b0;
      test_reset();
      test_add_5_3();
      test_hold_2_1();
      test_stray_bit();
      test_restart();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
